// File: rtl/flp_pkg.sv
// Shared definitions for the half-precision multiplier arbiter.
// Contents: the datapath width, the bit positions of the status flags, and the
// arbiter state encoding.
package flp_pkg;

  localparam int unsigned FLP_W = 16;

  // Bit positions in the 4-bit flag vector {overflow, zero, nan, precisionLost}
  localparam int unsigned FLG_OVF   = 3;
  localparam int unsigned FLG_ZERO  = 2;
  localparam int unsigned FLG_NAN   = 1;
  localparam int unsigned FLG_PLOST = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/float_multi.sv
// Combinational IEEE-754 binary16 multiplier.
// Ports:
//   num1, num2     operands {sign, exp[4:0], fra[9:0]}
//   result         product
//   overflow       result is infinite or overflowed the finite range
//   zero           result magnitude is zero
//   nan            result is NaN (NaN operand or 0 * inf)
//   precisionLost  bits were discarded while rounding
// Subnormal operands and results are supported. Rounding is toward +infinity:
// a positive inexact product rounds its magnitude up, and a negative one
// truncates. NaN results are the quiet NaN 0x7e00.
module float_multi
  import flp_pkg::*;
(
  input  logic [FLP_W-1:0] num1,
  input  logic [FLP_W-1:0] num2,
  output logic [FLP_W-1:0] result,
  output logic             overflow,
  output logic             zero,
  output logic             nan,
  output logic             precisionLost
);

  logic        sign;
  logic [4:0]  ex1, ex2, e1, e2, e_field;
  logic [9:0]  fr1, fr2, mant;
  logic [10:0] m1, m2;
  logic [21:0] prod;
  logic        nan1, nan2, inf1, inf2, zer1, zer2;
  logic [43:0] ext, lost_mask;
  logic        lost, inc;
  logic [14:0] mag;
  int          msb, e_sum, e_res, shamt;

  assign ex1  = num1[14:10];
  assign fr1  = num1[9:0];
  assign ex2  = num2[14:10];
  assign fr2  = num2[9:0];
  assign sign = num1[15] ^ num2[15];

  assign nan1 = (ex1 == 5'h1f) && (fr1 != '0);
  assign nan2 = (ex2 == 5'h1f) && (fr2 != '0);
  assign inf1 = (ex1 == 5'h1f) && (fr1 == '0);
  assign inf2 = (ex2 == 5'h1f) && (fr2 == '0);
  assign zer1 = (ex1 == '0) && (fr1 == '0);
  assign zer2 = (ex2 == '0) && (fr2 == '0);

  // Subnormals have no hidden bit and share the exponent of the smallest normal
  assign m1   = {|ex1, fr1};
  assign m2   = {|ex2, fr2};
  assign e1   = (ex1 == '0) ? 5'd1 : ex1;
  assign e2   = (ex2 == '0) ? 5'd1 : ex2;
  assign prod = {11'b0, m1} * {11'b0, m2};

  always_comb begin
    result        = '0;
    overflow      = 1'b0;
    zero          = 1'b0;
    nan           = 1'b0;
    precisionLost = 1'b0;
    msb           = 0;
    e_sum         = int'(e1) + int'(e2);
    e_res         = 0;
    shamt         = 0;
    ext           = {11'b0, prod, 11'b0};
    lost_mask     = '0;
    mant          = '0;
    lost          = 1'b0;
    inc           = 1'b0;
    e_field       = '0;
    mag           = '0;

    for (int i = 0; i < 22; i++) begin
      if (prod[i]) msb = i;
    end
    // Biased exponent of the exact product, normalised at its leading one
    e_res = msb + e_sum - 35;
    // Right shift of ext leaving the kept significand in ext[10:0]; a
    // subnormal result is aligned to the fixed 2^-24 grid instead
    shamt = (e_res >= 1) ? msb + 1 : 37 - e_sum;
    if (shamt > 43) shamt = 43;

    mant      = 10'(ext >> shamt);
    lost_mask = ~({44{1'b1}} << shamt);
    lost      = |(ext & lost_mask);
    inc       = lost & ~sign;
    e_field   = (e_res >= 1) ? 5'(e_res) : 5'd0;
    // A carry out of the fraction bumps the exponent, which also turns the
    // largest subnormal into the smallest normal
    mag       = {e_field, mant} + 15'(inc);

    if (nan1 || nan2 || (inf1 && zer2) || (zer1 && inf2)) begin
      result = 16'h7e00;
      nan    = 1'b1;
    end else if (inf1 || inf2) begin
      result   = {sign, 5'h1f, 10'h0};
      overflow = 1'b1;
    end else if (zer1 || zer2) begin
      result = {sign, 15'h0};
      zero   = 1'b1;
    end else if ((e_res >= 31) || (mag[14:10] == 5'h1f)) begin
      result        = sign ? 16'hfbff : 16'h7c00;
      overflow      = 1'b1;
      precisionLost = 1'b1;
    end else begin
      result        = {sign, mag};
      zero          = (mag == '0);
      precisionLost = lost;
    end
  end

endmodule

// File: rtl/flpm_arbiter.sv
// Two-port round-robin arbiter sharing one float_multi between two requesters.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqX_valid/a/b/ready      requester X operands with valid/ready handshake
//   res_valid/data/id/flags   registered result, held until res_ready
//   res_ready                 consumer accepts the result
//   sticky_flags, clr_flags   cumulative OR of res_flags and its clear
//   busy                      high while an operation is in CALC or HOLD
// One operation at a time: IDLE grants and latches operands, CALC registers
// the product, HOLD presents it until consumed.
module flpm_arbiter
  import flp_pkg::*;
#(
  parameter int unsigned HOLD_FLAGS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [FLP_W-1:0] req0_a,
  input  logic [FLP_W-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [FLP_W-1:0] req1_a,
  input  logic [FLP_W-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [FLP_W-1:0] res_data,
  output logic             res_id,
  output logic [3:0]       res_flags,
  input  logic             res_ready,
  output logic [3:0]       sticky_flags,
  input  logic             clr_flags,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [FLP_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic             res_valid_q, res_valid_d;
  logic [FLP_W-1:0] res_data_q, res_data_d;
  logic             res_id_q, res_id_d;
  logic [3:0]       res_flags_q, res_flags_d;
  logic [3:0]       sticky_q, sticky_d;

  logic             grant_any, grant_id, accept;
  logic [FLP_W-1:0] fm_result;
  logic             fm_ovf, fm_zero, fm_nan, fm_plost;
  logic [3:0]       fm_flags;

  float_multi u_float_multi (
    .num1          (op_a_q),
    .num2          (op_b_q),
    .result        (fm_result),
    .overflow      (fm_ovf),
    .zero          (fm_zero),
    .nan           (fm_nan),
    .precisionLost (fm_plost)
  );

  always_comb begin
    fm_flags            = '0;
    fm_flags[FLG_OVF]   = fm_ovf;
    fm_flags[FLG_ZERO]  = fm_zero;
    fm_flags[FLG_NAN]   = fm_nan;
    fm_flags[FLG_PLOST] = fm_plost;
  end

  // Round robin: on contention the requester that did not win last time wins
  assign grant_any  = req0_valid | req1_valid;
  assign grant_id   = (req0_valid & req1_valid) ? ~last_q : req1_valid;
  // rst gates the handshake so nothing is accepted on a reset edge
  assign accept     = (state_q == IDLE) & grant_any & ~rst;
  assign req0_ready = accept & ~grant_id;
  assign req1_ready = accept & grant_id;
  assign busy       = (state_q != IDLE) & ~rst;

  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_id       = res_id_q;
  assign res_flags    = res_flags_q;
  assign sticky_flags = sticky_q;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_flags_d = res_flags_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CALC;
          last_d  = grant_id;
          id_d    = grant_id;
          op_a_d  = grant_id ? req1_a : req0_a;
          op_b_d  = grant_id ? req1_b : req0_b;
        end
      end
      CALC: begin
        state_d     = HOLD;
        res_valid_d = 1'b1;
        res_data_d  = fm_result;
        res_id_d    = id_q;
        res_flags_d = fm_flags;
      end
      HOLD: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A clear coinciding with a capture still keeps the new flags
    sticky_d = clr_flags ? '0 : sticky_q;
    if (state_q == CALC) sticky_d = sticky_d | fm_flags;
    if (HOLD_FLAGS == 0) sticky_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
      res_flags_q <= '0;
      sticky_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_flags_q <= res_flags_d;
      sticky_q    <= sticky_d;
    end
  end

endmodule

// File: tb/tb_flpm_arbiter.sv
// Bench for flpm_arbiter: expected results are queued when requests are driven
// and compared by a monitor when the DUT hands a result to the consumer. A
// second instance with HOLD_FLAGS = 0 shares the same stimulus.
module tb_flpm_arbiter;

  typedef struct packed {
    logic [15:0] data;
    logic        id;
    logic [3:0]  flags;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        res_ready = 1'b0, clr_flags = 1'b0;

  logic        req0_ready, req1_ready, res_valid, res_id, busy;
  logic [15:0] res_data;
  logic [3:0]  res_flags, sticky_flags;

  logic        nf_req0_ready, nf_req1_ready, nf_res_valid, nf_res_id, nf_busy;
  logic [15:0] nf_res_data;
  logic [3:0]  nf_res_flags, nf_sticky;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  flpm_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_ready   (req1_ready),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_id       (res_id),
    .res_flags    (res_flags),
    .res_ready    (res_ready),
    .sticky_flags (sticky_flags),
    .clr_flags    (clr_flags),
    .busy         (busy)
  );

  flpm_arbiter #(.HOLD_FLAGS(0)) dut_nf (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_ready   (nf_req0_ready),
    .req1_valid   (req1_valid),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_ready   (nf_req1_ready),
    .res_valid    (nf_res_valid),
    .res_data     (nf_res_data),
    .res_id       (nf_res_id),
    .res_flags    (nf_res_flags),
    .res_ready    (res_ready),
    .sticky_flags (nf_sticky),
    .clr_flags    (clr_flags),
    .busy         (nf_busy)
  );

  // Scoreboard monitor: every consumed result must match the oldest expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && res_valid && res_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got data=%h id=%0d flags=%b, required no result",
                 res_data, res_id, res_flags);
      end else begin
        e = sb_q.pop_front();
        if ({res_data, res_id, res_flags} !== {e.data, e.id, e.flags}) begin
          errors++;
          $display("FAIL result: got data=%h id=%0d flags=%b, required data=%h id=%0d flags=%b",
                   res_data, res_id, res_flags, e.data, e.id, e.flags);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise one request, wait for its ready and drop valid after the accept edge.
  // Returns one step after the accept edge, i.e. while the DUT is in CALC.
  task automatic issue(input bit port, input logic [15:0] a, input logic [15:0] b,
                       input bit push, input logic [15:0] ed, input logic [3:0] ef);
    int k;
    if (push) sb_q.push_back(exp_t'{data: ed, id: port, flags: ef});
    if (port) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    k = 0;
    @(negedge clk);
    while (!(port ? req1_ready : req0_ready) && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 20) begin
      errors++;
      $display("FAIL issue_grant: port %0d ready=0 after 20 cycles, required 1", port);
    end
    tick();
    if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 30) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after 30 cycles, required 0", busy);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready_busy: got r0=%b r1=%b busy=%b, required 0 0 0",
               req0_ready, req1_ready, busy);
    end
    checks++;
    if ({res_valid, res_data, res_id, res_flags} !== 22'h0) begin
      errors++;
      $display("FAIL reset_res: got v=%b d=%h id=%b f=%b, required all 0",
               res_valid, res_data, res_id, res_flags);
    end
    checks++;
    if ({sticky_flags, nf_sticky} !== 8'h0) begin
      errors++;
      $display("FAIL reset_sticky: got %b/%b, required 0000/0000", sticky_flags, nf_sticky);
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
  endtask

  // Both requesters valid together: requester 0 must win whenever last grant was 1
  task automatic test_contention();
    int k;
    res_ready = 1'b1;
    sb_q.push_back(exp_t'{data: 16'h801b, id: 1'b0, flags: 4'b0001});
    sb_q.push_back(exp_t'{data: 16'h4600, id: 1'b1, flags: 4'b0000});
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h9876;
    req1_valid = 1'b1; req1_a = 16'h4000; req1_b = 16'h4200;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL contention_first: got r0=%b r1=%b, required r0=1 r1=0",
               req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!req1_ready && k < 20);
    checks++;
    if (k !== 3) begin
      errors++;
      $display("FAIL contention_gap: second grant after %0d cycles, required 3", k);
    end
    tick();
    req1_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    sb_q.push_back(exp_t'{data: 16'h00f2, id: 1'b0, flags: 4'b0001});
    req0_valid = 1'b1; req0_a = 16'h4689; req0_b = 16'h0025;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL single_ready: got r0=%b r1=%b, required r0=1 r1=0", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({res_valid, busy} !== 2'b01) begin
      errors++;
      $display("FAIL single_calc: got valid=%b busy=%b, required valid=0 busy=1", res_valid, busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({res_valid, busy} !== 2'b11) begin
      errors++;
      $display("FAIL single_hold: got valid=%b busy=%b, required valid=1 busy=1", res_valid, busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({res_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle: got valid=%b busy=%b, required valid=0 busy=0", res_valid, busy);
    end
    tick();
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    issue(1'b0, 16'h4000, 16'h4200, 1'b1, 16'h4600, 4'b0000);
    sb_q.push_back(exp_t'{data: 16'h801b, id: 1'b1, flags: 4'b0001});
    req1_valid = 1'b1; req1_a = 16'h1234; req1_b = 16'h9876;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({res_valid, res_data, req0_ready, req1_ready} !== {1'b1, 16'h4600, 2'b00}) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got v=%b d=%h r0=%b r1=%b, required v=1 d=4600 r0=0 r1=0",
                 i, res_valid, res_data, req0_ready, req1_ready);
      end
      tick();
    end
    res_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({busy, res_valid, req1_ready} !== 3'b001) begin
      errors++;
      $display("FAIL backpressure_release: got busy=%b v=%b r1=%b, required busy=0 v=0 r1=1",
               busy, res_valid, req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_flags();
    res_ready = 1'b1;
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    checks++;
    if (sticky_flags !== 4'b0000) begin
      errors++;
      $display("FAIL flags_clear0: got sticky=%b, required 0000", sticky_flags);
    end
    issue(1'b0, 16'h7e00, 16'h3c00, 1'b1, 16'h7e00, 4'b0010);
    tick();
    @(negedge clk);
    checks++;
    if ({res_flags[1], sticky_flags} !== 5'b1_0010) begin
      errors++;
      $display("FAIL flags_nan: got nan=%b sticky=%b, required nan=1 sticky=0010",
               res_flags[1], sticky_flags);
    end
    checks++;
    if ({nf_res_flags, nf_sticky} !== 8'b0010_0000) begin
      errors++;
      $display("FAIL flags_nohold: got res_flags=%b sticky=%b, required 0010 0000",
               nf_res_flags, nf_sticky);
    end
    wait_idle();
    issue(1'b0, 16'h4000, 16'h4200, 1'b1, 16'h4600, 4'b0000);
    wait_idle();
    checks++;
    if (sticky_flags !== 4'b0010) begin
      errors++;
      $display("FAIL flags_keep: got sticky=%b, required 0010", sticky_flags);
    end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    checks++;
    if (sticky_flags !== 4'b0000) begin
      errors++;
      $display("FAIL flags_clear: got sticky=%b, required 0000", sticky_flags);
    end
    issue(1'b0, 16'h7e00, 16'h3c00, 1'b1, 16'h7e00, 4'b0010);
    wait_idle();
    // Clear during CALC: the capture edge keeps only the new result's flags
    issue(1'b1, 16'h4000, 16'h7c00, 1'b1, 16'h7c00, 4'b1000);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    checks++;
    if ({sticky_flags, nf_sticky} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL flags_clr_capture: got sticky=%b nf=%b, required 1000 0000",
               sticky_flags, nf_sticky);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b1;
    issue(1'b0, 16'h4000, 16'h4200, 1'b0, 16'h0, 4'h0);
    rst = 1'b1;
    req1_valid = 1'b1; req1_a = 16'h3c00; req1_b = 16'h3c00;
    @(negedge clk);
    checks++;
    if ({busy, req0_ready, req1_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_gate: got busy=%b r0=%b r1=%b, required 0 0 0",
               busy, req0_ready, req1_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({busy, res_valid, res_data, req1_ready} !== 19'h0) begin
      errors++;
      $display("FAIL reset_mid_state: got busy=%b v=%b d=%h r1=%b, required all 0",
               busy, res_valid, res_data, req1_ready);
    end
    tick();
    rst = 1'b0;
    sb_q.push_back(exp_t'{data: 16'h3c00, id: 1'b1, flags: 4'b0000});
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid_grant: got r0=%b r1=%b, required r0=0 r1=1", req0_ready, req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    wait_idle();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation still running at 200000, required to finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_contention();
    test_contention();
    test_single();
    test_backpressure();
    test_flags();
    test_reset_mid();
    repeat (3) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
